// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package shifter_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: shift or rotate value by s (0..STEP) positions.
module shift_step
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       op,
  input  logic [SW-1:0]    s,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    shifted = value;
    case (op)
      OP_SLL:  shifted = value << s;
      OP_SRL:  shifted = value >> s;
      OP_SRA:  shifted = $unsigned($signed(value) >>> s);
      // a shift by WIDTH yields zero, so s=0 leaves only the identity term
      OP_ROL:  shifted = (value << s) | (value >> (WIDTH - int'(s)));
      OP_ROR:  shifted = (value >> s) | (value << (WIDTH - int'(s)));
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: consumes up to STEP positions per clock with a
// start/busy/done handshake so the datapath controller can stall on it.
//
// state    | meaning
// ST_IDLE  | waiting for start, busy=0
// ST_SHIFT | iterating on acc until the remaining count reaches zero, busy=1
module seq_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amount,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SW = $clog2(STEP + 1);
  localparam logic [AW:0] STEP_W = (AW + 1)'(STEP);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [2:0]       opq_q, opq_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [AW:0]      rem_ext, s_ext;
  logic [AW-1:0]    rem_nxt;
  logic [SW-1:0]    s_eff;
  logic             pass_op;
  logic [WIDTH-1:0] step_val;

  // STEP may equal WIDTH, so the min() is done one bit wider than rem
  assign rem_ext = {1'b0, rem_q};
  assign s_ext   = (rem_ext > STEP_W) ? STEP_W : rem_ext;
  assign rem_nxt = AW'(rem_ext - s_ext);
  assign pass_op = (opq_q > OP_ROR);
  assign s_eff   = pass_op ? '0 : SW'(s_ext);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .value   (acc_q),
    .op      (opq_q),
    .s       (s_eff),
    .shifted (step_val)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opq_d    = opq_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = operand;
          rem_d   = amount;
          opq_d   = op;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = step_val;
        rem_d = rem_nxt;
        if (rem_nxt == '0) begin
          result_d = step_val;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      opq_q    <= OP_SLL;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opq_q    <= opq_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised, multi-cycle iterative shifter for the multicycle datapath, and the successor to the single-cycle combinational shifter.
- Shifts by up to STEP bit positions per clock, which trades latency for area and keeps a short timing path.
- Adds rotate modes, generic width and a start/busy/done handshake, so the control FSM can stall on it like the multiplier/divider.
- STEP=WIDTH degenerates to a one-iteration shifter.

Parameters:
- WIDTH, 32: operand/result width; power of 2, at least 8.
- STEP, 4: maximum positions shifted per cycle; power of 2, 1..WIDTH.
- AW, $clog2(WIDTH): shift-amount width (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101..111 are pass-through.
- amount  input  AW  shift/rotate count 0..WIDTH-1.
- operand  input  WIDTH  value to shift.
- busy  output  1  operation in progress; start is ignored while high.
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- result  output  WIDTH  final value; held until the next accepted start completes.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset rst_n is asynchronous, active-low.
  - On reset: state=IDLE, busy=0, done=0, result=0, internal shift register and remaining count cleared.
  - Reset asserted mid-operation aborts immediately; no done pulse is produced.
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
  - done is a registered flag, not a separate state.
- Accept, on the edge where busy=0 and start=1:
  - Load acc<=operand, rem<=amount, opq<=op.
  - Go to SHIFT.
  - done<=0 on that edge.
- In SHIFT, each edge:
  - s = min(rem, STEP); acc <= f(acc, opq, s); rem <= rem - s.
  - If rem - s == 0: result<=f(acc, opq, s), state<=IDLE, done<=1.
  - Otherwise stay in SHIFT with done=0.
- done is high for exactly one cycle. It drops on the next edge unless a new operation completes on that edge.
- Latency:
  - done visible D = max(1, ceil(amount/STEP)) cycles after the accepting edge.
  - amount=0 takes one cycle and gives result=operand.
  - Pass-through ops take D cycles with s treated as 0, so result=operand.
- Per-step function f:
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA fills with acc[WIDTH-1] of the current value; this is equivalent to the original sign bit.
  - ROL/ROR wrap bits end-around; a rotate by 0 is the identity.
- Back-to-back: in the cycle done=1, busy is already 0. A start in that cycle is accepted, giving zero bubble between operations.
- start while busy=1 is ignored entirely, with no queueing. Changes to op/amount/operand while busy have no effect.
- result changes only on a completing edge and on reset.

Decomposition:
- Package shifter_pkg holds:
  - op encodings: OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR;
  - state encodings: ST_IDLE, ST_SHIFT;
  - a function or constant for step-count computation, if shared with the bench.
- Sub-module shift_step: purely combinational; inputs value[WIDTH], op, s[$clog2(STEP+1)]; output shifted value.
  - It is instantiated once inside seq_shifter.
  - The bench exercises it standalone against a reference model.
- Top module holds FSM, acc/rem/opq registers, result and done.

Test Plan (WIDTH=32, STEP=4):
- Reset: rst_n low with random inputs -> busy=0, done=0, result=0x00000000. Release, idle 5 cycles -> outputs unchanged.
- SRA: operand=0x80000000, amount=31 -> busy for 8 cycles; done pulse once on cycle 8; result=0xFFFFFFFF. SRL with the same inputs -> 0x00000001.
- ROR: operand=0x12345678, amount=4 -> done after 1 cycle, result=0x81234567. ROL amount=8 -> 0x34567812 after 2 cycles.
- Zero and pass-through:
  - SLL operand=0x00000001, amount=0 -> done after 1 cycle, result=0x00000001.
  - op=111, amount=12 -> result=0x00000001 after 3 cycles.
- Handshake:
  - SLL 0x1 by 9, D=3; pulse start again on cycles 1-2 with other data -> ignored, result=0x00000200.
  - Start asserted in the done cycle -> accepted, second done follows with no idle gap.
- Abort: SRA 0xF0000000 by 20, assert rst_n low at cycle 2 -> busy=0, done=0, result=0 immediately; no done after release. A new SRL 0xF0000000 by 28 -> 0x0000000F.
